// File: rtl/lemmings_3.sv
// Moore FSM for one Lemming: walks left/right, falls when ground vanishes, digs on request.
// Define LEMMINGS_SPLAT_EN to add a fall counter and an absorbing SPLAT state for long falls.
module lemmings_3 #(
  parameter int SPLAT_CYCLES = 20
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging
);

  typedef enum logic [2:0] {
    WALK_L,
    WALK_R,
    FALL_L,
    FALL_R,
    DIG_L,
    DIG_R
`ifdef LEMMINGS_SPLAT_EN
    , SPLAT
`endif
  } state_t;

  state_t state_q, state_d;
  logic   walk_left_q, walk_right_q, aaah_q, digging_q;

  // Output vector order: {walk_left, walk_right, aaah, digging}.
  function automatic logic [3:0] decode(input state_t s);
    logic [3:0] o;
    o = 4'b0000;
    case (s)
      WALK_L:         o = 4'b1000;
      WALK_R:         o = 4'b0100;
      FALL_L, FALL_R: o = 4'b0010;
      DIG_L, DIG_R:   o = 4'b0001;
      default:        o = 4'b0000;
    endcase
    return o;
  endfunction

  function automatic logic is_fall(input state_t s);
    return (s == FALL_L) || (s == FALL_R);
  endfunction

`ifdef LEMMINGS_SPLAT_EN
  localparam int CNT_W = $clog2(SPLAT_CYCLES + 2);
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // fall_cnt_q holds the number of completed fall cycles before the current one,
  // so landing after more than SPLAT_CYCLES cycles means fall_cnt_q >= SPLAT_CYCLES.
  logic too_long;
  assign too_long = (fall_cnt_q >= CNT_W'(SPLAT_CYCLES));
`else
  logic too_long;
  assign too_long = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      WALK_L: begin
        if (!ground)        state_d = FALL_L;
        else if (dig)       state_d = DIG_L;
        else if (bump_left) state_d = WALK_R;
      end
      WALK_R: begin
        if (!ground)         state_d = FALL_R;
        else if (dig)        state_d = DIG_R;
        else if (bump_right) state_d = WALK_L;
      end
      FALL_L: if (ground) state_d = too_long ? `ifdef LEMMINGS_SPLAT_EN SPLAT `else WALK_L `endif : WALK_L;
      FALL_R: if (ground) state_d = too_long ? `ifdef LEMMINGS_SPLAT_EN SPLAT `else WALK_R `endif : WALK_R;
      DIG_L:  if (!ground) state_d = FALL_L;
      DIG_R:  if (!ground) state_d = FALL_R;
      default: state_d = state_q;
    endcase
  end

`ifdef LEMMINGS_SPLAT_EN
  always_comb begin
    fall_cnt_d = '0;
    if (is_fall(state_d) && is_fall(state_q)) fall_cnt_d = sat_inc(fall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!areset) fall_cnt_q <= '0;
    else         fall_cnt_q <= fall_cnt_d;
  end
`endif

  // Outputs are registered from the next state so they stay a pure function of state.
  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q      <= WALK_L;
      walk_left_q  <= 1'b1;
      walk_right_q <= 1'b0;
      aaah_q       <= 1'b0;
      digging_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      {walk_left_q, walk_right_q, aaah_q, digging_q} <= decode(state_d);
    end
  end

  assign walk_left  = walk_left_q;
  assign walk_right = walk_right_q;
  assign aaah       = aaah_q;
  assign digging    = digging_q;

endmodule

// File: tb/tb_lemmings_3.sv
// Self-checking bench for lemmings_3: directed test-plan scenarios plus randomized
// stimulus compared against a behavioural model of the Lemming's rules.
module tb_lemmings_3;
  localparam int SPLAT_CYCLES = 20;

  logic clk = 1'b0;
  logic areset, bump_left, bump_right, ground, dig;
  logic walk_left, walk_right, aaah, digging;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: activity + remembered direction + length of current fall.
  typedef enum int {M_WALK, M_FALL, M_DIG, M_SPLAT} mode_t;
  mode_t m_mode;
  bit    m_right;
  int    m_fall_len;

  lemmings_3 #(.SPLAT_CYCLES(SPLAT_CYCLES)) dut (
    .clk       (clk),
    .areset    (areset),
    .bump_left (bump_left),
    .bump_right(bump_right),
    .ground    (ground),
    .dig       (dig),
    .walk_left (walk_left),
    .walk_right(walk_right),
    .aaah      (aaah),
    .digging   (digging)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {wl,wr,aaah,dig}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_out();
    case (m_mode)
      M_WALK:  return m_right ? 4'b0100 : 4'b1000;
      M_FALL:  return 4'b0010;
      M_DIG:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic void model_edge(bit rst_n, bit bl, bit br, bit g, bit d);
    bit splat_en;
`ifdef LEMMINGS_SPLAT_EN
    splat_en = 1'b1;
`else
    splat_en = 1'b0;
`endif
    if (!rst_n) begin
      m_mode = M_WALK; m_right = 1'b0; m_fall_len = 0;
      return;
    end
    case (m_mode)
      M_WALK: begin
        if (!g) begin m_mode = M_FALL; m_fall_len = 0; end
        else if (d) m_mode = M_DIG;
        else if ((m_right && br) || (!m_right && bl)) m_right = !m_right;
      end
      M_FALL: begin
        m_fall_len++;   // the cycle just ending was spent falling
        if (g) m_mode = (splat_en && m_fall_len > SPLAT_CYCLES) ? M_SPLAT : M_WALK;
      end
      M_DIG: if (!g) begin m_mode = M_FALL; m_fall_len = 0; end
      default: ;
    endcase
  endfunction

  logic [3:0] outs;
  assign outs = {walk_left, walk_right, aaah, digging};

  // Apply inputs away from the edge, clock once, update model, sample 1 time unit later.
  task automatic step(input bit rst_n, input bit bl, input bit br, input bit g, input bit d);
    @(negedge clk);
    areset = rst_n; bump_left = bl; bump_right = br; ground = g; dig = d;
    @(posedge clk);
    model_edge(rst_n, bl, br, g, d);
    #1;
  endtask

  task automatic step_chk(input string tag, input bit rst_n, input bit bl, input bit br,
                          input bit g, input bit d, input logic [3:0] want);
    step(rst_n, bl, br, g, d);
    check({tag, "/const"}, outs, want);
    check({tag, "/model"}, outs, model_out());
  endtask

  initial begin
    areset = 1'b0; bump_left = 1'b0; bump_right = 1'b0; ground = 1'b1; dig = 1'b0;

    // Reset and bumps
    step_chk("reset",      0, 0, 0, 1, 0, 4'b1000);
    step_chk("idle_l",     1, 0, 1, 1, 0, 4'b1000);
    step_chk("bump_l",     1, 1, 0, 1, 0, 4'b0100);
    step_chk("bump_both",  1, 1, 1, 1, 0, 4'b1000);
    step_chk("bump_r_opp", 1, 0, 1, 1, 0, 4'b1000);
    step_chk("bump_l2",    1, 1, 0, 1, 0, 4'b0100);

    // Fall while walking right, bumps toggling
    for (int i = 0; i < 3; i++) step_chk("fall_r", 1, i[0], !i[0], 0, 1, 4'b0010);
    step_chk("land_r", 1, 0, 0, 1, 0, 4'b0100);
    step_chk("bump_r", 1, 0, 1, 1, 0, 4'b1000);

    // Dig from WALK_L
    step_chk("dig_l",      1, 0, 0, 1, 1, 4'b0001);
    step_chk("dig_hold",   1, 1, 1, 1, 0, 4'b0001);
    step_chk("dig_bump",   1, 1, 0, 1, 1, 4'b0001);
    step_chk("dig_fall",   1, 0, 0, 0, 0, 4'b0010);
    step_chk("dig_land",   1, 0, 0, 1, 0, 4'b1000);

    // Priority in WALK_R
    step_chk("to_r",       1, 1, 0, 1, 0, 4'b0100);
    step_chk("prio_fall",  1, 0, 1, 0, 1, 4'b0010);
    step_chk("prio_land",  1, 0, 0, 1, 0, 4'b0100);
    step_chk("prio_dig",   1, 0, 1, 1, 1, 4'b0001);

    // Reset mid-dig (DIG_R)
    step_chk("rst_dig",    0, 0, 0, 1, 1, 4'b1000);

    // Fall of exactly SPLAT_CYCLES cycles always survives
    step_chk("f20_start",  1, 0, 0, 0, 0, 4'b0010);
    for (int i = 1; i < SPLAT_CYCLES; i++) step_chk("f20_fall", 1, 0, 0, 0, 0, 4'b0010);
    step_chk("f20_land",   1, 0, 0, 1, 0, 4'b1000);

    // Fall of SPLAT_CYCLES+1 cycles
    step_chk("f21_start",  1, 0, 0, 0, 0, 4'b0010);
    for (int i = 1; i < SPLAT_CYCLES + 1; i++) step_chk("f21_fall", 1, 0, 0, 0, 0, 4'b0010);
`ifdef LEMMINGS_SPLAT_EN
    step_chk("f21_splat",  1, 0, 0, 1, 0, 4'b0000);
    for (int i = 0; i < 8; i++)
      step_chk("splat_hold", 1, i[0], i[1], i[2], 1, 4'b0000);
`else
    step_chk("f21_land",   1, 0, 0, 1, 0, 4'b1000);
`endif
    step_chk("rst_after",  0, 1, 1, 0, 1, 4'b1000);

    // Randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      bit rn, bl, br, g, d;
      rn = ($urandom_range(0, 59) != 0);
      bl = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 3) == 0;
      g  = (i % 100 > 60 && i % 100 < 85) ? 1'b0 : ($urandom_range(0, 4) != 0);
      d  = $urandom_range(0, 5) == 0;
      step(rn, bl, br, g, d);
      check("random", outs, model_out());
      check("onehot", {3'b000, $countones(outs) <= 1}, 4'b0001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
